// File: rtl/spi_slave.sv
// spi_slave: SPI responder clocked entirely by clk. spi_clk, cs and mosi are
// oversampled through a synchronizer plus one history flop. All four CPOL/CPHA
// modes are supported. Received words are assembled MSB-first, and a response
// word is shifted out on miso.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   polarity, phase    CPOL/CPHA, latched at the cs falling edge
//   spi_clk, cs, mosi  raw SPI pins (asynchronous; cs is active-low)
//   miso, miso_oe      serial response and its drive enable
//   tx_data, tx_ack    response word, sampled when tx_ack pulses
//   rx_data, rx_valid  last complete word and its one-cycle update strobe
//   frame_err          one-cycle pulse when cs rises mid-word
//   count, state       bits remaining in the current word / FSM state (debug)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_HIGH | after reset; ignore everything until the synchronized cs is high
// IDLE      | bus idle; wait for a cs falling edge
// SHIFT     | frame active; sample and shift on spi_clk edges
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              phase,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic [3:0]        count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  localparam logic [3:0] CNT_FULL = 4'(DATA_W);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;

  state_t                 state_q, state_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic                   byte_done_q, byte_done_d;
  logic [3:0]             count_q, count_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_ack_q, tx_ack_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  // cs synchronizer resets to 0 so WAIT_HIGH only leaves on a genuine high cs,
  // never on a stale reset value while a frame is still in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    byte_done_d = byte_done_q;
    count_d     = count_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      WAIT_HIGH: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          cpol_d      = polarity;
          cpha_d      = phase;
          tx_shift_d  = tx_data;
          tx_ack_d    = 1'b1;
          byte_done_d = phase;
          count_d     = CNT_FULL;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // A cs edge takes priority over any spi_clk edge seen in the same clk.
        if (cs_rise) begin
          if (count_q != CNT_FULL) frame_err_d = 1'b1;
          count_d = CNT_FULL;
          state_d = IDLE;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (count_q == 4'd1) begin
              rx_data_d   = {rx_shift_q[DATA_W-2:0], mosi_s};
              rx_valid_d  = 1'b1;
              count_d     = CNT_FULL;
              byte_done_d = 1'b1;
            end else begin
              count_d = count_q - 4'd1;
            end
          end
          // Sample and shift edges are opposite spi_clk edges, never both.
          if (shift_edge) begin
            if (byte_done_q) begin
              tx_shift_d  = tx_data;
              tx_ack_d    = 1'b1;
              byte_done_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_HIGH;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      byte_done_q <= 1'b0;
      count_q     <= CNT_FULL;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      byte_done_q <= byte_done_d;
      count_q     <= count_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ack_q    <= tx_ack_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso_oe   = (state_q == SHIFT);
  assign miso      = (state_q == SHIFT) ? tx_shift_q[DATA_W-1] : 1'b1;
  assign tx_ack    = tx_ack_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign count     = count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master drives frames in all four modes.
// Expected rx words, frame errors, tx_ack counts and the words the master reads
// back are predicted from frame-level rules and checked by a per-cycle monitor
// plus end-of-frame checks.
module tb_spi_slave;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset, polarity, phase, spi_clk, cs, mosi;
  logic [DW-1:0] tx_data;
  logic          miso, miso_oe, tx_ack, rx_valid, frame_err;
  logic [DW-1:0] rx_data;
  logic [3:0]    count;
  logic [1:0]    state;

  spi_slave #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .phase(phase),
    .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .count(count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int c; } rxe_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         ack_seen = 0;
  int         exp_acks = 0;
  int         ferr_pend = 0;
  bit         chk_on   = 1'b0;
  logic [7:0] last_rx  = 8'h00;
  logic [7:0] resp_arr [512];
  logic [7:0] mw [4];
  logic [7:0] mr [4];
  rxe_t       rxq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic bit_of(input int i);
    logic [7:0] w;
    w = mw[i/8];
    return w[7-(i%8)];
  endfunction

  function automatic void set_resp(input int off, input logic [7:0] v);
    resp_arr[(exp_acks + off) % 512] = v;
  endfunction

  // Response feeder: after every tx_ack the next response word is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_ack) begin
        ack_seen++;
        tx_data = resp_arr[ack_seen % 512];
      end
    end
  end

  // Per-cycle monitor.
  initial begin
    rxe_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (chk_on && !reset) begin
        if (!miso_oe) check("miso_idle_high", miso, 1'b1);
        check("count_in_range", (count >= 4'd1) && (count <= 4'd8), 1'b1);
        if (rxq.size() == 0) begin
          check("rx_valid_spurious", rx_valid, 1'b0);
          check("rx_data_hold", rx_data, last_rx);
        end else if (rx_valid) begin
          e   = rxq.pop_front();
          lat = cyc - e.c;
          check("rx_data", rx_data, e.d);
          check("rx_latency_ok", (lat >= 1) && (lat <= SS + 2), 1'b1);
          last_rx = e.d;
        end else begin
          check("rx_data_hold", rx_data, last_rx);
          if (cyc - rxq[0].c > SS + 2) begin
            check("rx_valid_timeout", rx_valid, 1'b1);
            void'(rxq.pop_front());
          end
        end
        if (ferr_pend == 0) check("frame_err_spurious", frame_err, 1'b0);
        else if (frame_err) ferr_pend--;
      end
    end
  end

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    rxq.delete();
    ferr_pend = 0;
    last_rx   = 8'h00;
    repeat (n) @(negedge clk);
    check("rst_miso", miso, 1'b1);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_ack", tx_ack, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_count", count, 4'd8);
    check("rst_state", state, 2'd0);
    reset = 1'b0;
  endtask

  task automatic sample_bit(input int i, input bit aborted);
    logic [7:0] w;
    w = mr[i/8];
    w[7-(i%8)] = miso;
    mr[i/8] = w;
    if (!aborted) begin
      check("miso_oe_in_frame", miso_oe, 1'b1);
      if (i % 8 == 7) rxq.push_back('{d: mw[i/8], c: cyc});
    end
  endtask

  // One frame of nbits bits. toggle_at flips the polarity/phase pins before that
  // bit; rst_at pulses reset before that bit (-1 disables either).
  task automatic run_frame(input bit cpol, input bit cpha, input int nbits,
                           input int toggle_at, input int rst_at);
    int base, half, nb_eff;
    bit aborted;
    aborted = 1'b0;
    @(negedge clk);
    spi_clk  = cpol;
    polarity = cpol;
    phase    = cpha;
    mosi     = 1'b0;
    repeat (4) @(negedge clk);
    tx_data = resp_arr[ack_seen % 512];
    base    = exp_acks;
    for (int k = 0; k < 4; k++) mr[k] = 8'h00;
    @(negedge clk);
    cs = 1'b0;
    if (!cpha) mosi = bit_of(0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == toggle_at) begin
        polarity = ~polarity;
        phase    = ~phase;
      end
      if (i == rst_at) begin
        pulse_reset(2);
        aborted = 1'b1;
      end
      half = $urandom_range(10, 6);
      spi_clk = ~cpol;
      if (!cpha) sample_bit(i, aborted);
      else mosi = bit_of(i);
      repeat (half) @(negedge clk);
      spi_clk = cpol;
      if (cpha) sample_bit(i, aborted);
      else if (i + 1 < nbits) mosi = bit_of(i + 1);
      repeat (half) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    if (aborted) check("state_wait_high", state, 2'd0);
    cs = 1'b1;
    nb_eff = aborted ? rst_at : nbits;
    if (!aborted && (nbits % 8 != 0)) ferr_pend++;
    exp_acks += 1 + nb_eff / 8 + ((cpha && (nb_eff % 8 != 0)) ? 1 : 0);
    repeat (10) @(negedge clk);
    check("rx_all_delivered", rxq.size(), 0);
    check("frame_err_delivered", ferr_pend, 0);
    check("tx_ack_total", ack_seen, exp_acks);
    check("count_after_frame", count, 4'd8);
    check("state_after_frame", state, 2'd1);
    check("miso_oe_after_frame", miso_oe, 1'b0);
    if (!aborted)
      for (int k = 0; k < nbits / 8; k++)
        check("master_read", mr[k], resp_arr[(base + cpha + k) % 512]);
  endtask

  initial begin
    int nb, tg, ra;
    bit cp, ch;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, tg, ra;
    bit cp, ch;
    reset = 1'b0; polarity = 1'b0; phase = 1'b0; spi_clk = 1'b0;
    cs = 1'b1; mosi = 1'b0;
    for (int k = 0; k < 512; k++) resp_arr[k] = 8'($urandom);
    tx_data = resp_arr[0];
    @(negedge clk);
    pulse_reset(3);
    chk_on = 1'b1;
    repeat (6) @(negedge clk);
    check("state_idle_after_reset", state, 2'd1);

    // Mode 00: send A5, respond 3C.
    set_resp(0, 8'h3C);
    mw[0] = 8'hA5;
    run_frame(1'b0, 1'b0, 8, -1, -1);
    check("m00_rx_literal", rx_data, 8'hA5);
    check("m00_miso_literal", mr[0], 8'h3C);

    // Mode 11: send 5A, respond C3 (word loaded at the first leading edge).
    set_resp(0, 8'hC3);
    set_resp(1, 8'hC3);
    mw[0] = 8'h5A;
    run_frame(1'b1, 1'b1, 8, -1, -1);
    check("m11_rx_literal", rx_data, 8'h5A);
    check("m11_miso_literal", mr[0], 8'hC3);
    check("m11_count_literal", count, 4'd8);

    // Mode 01 two-word frame: 12, 34 in; F0 then 0F out.
    set_resp(0, 8'hF0);
    set_resp(1, 8'hF0);
    set_resp(2, 8'h0F);
    mw[0] = 8'h12; mw[1] = 8'h34;
    run_frame(1'b0, 1'b1, 16, -1, -1);
    check("m01_rx_literal", rx_data, 8'h34);
    check("m01_miso0_literal", mr[0], 8'hF0);
    check("m01_miso1_literal", mr[1], 8'h0F);

    // Mode 00 aborted after 5 bits, then a clean frame.
    mw[0] = 8'hE7;
    run_frame(1'b0, 1'b0, 5, -1, -1);
    check("abort_rx_unchanged", rx_data, 8'h34);
    mw[0] = 8'h96;
    run_frame(1'b0, 1'b0, 8, -1, -1);
    check("after_abort_rx", rx_data, 8'h96);

    // Mode 10 with reset after 3 bits, then a clean frame.
    mw[0] = 8'hFF;
    run_frame(1'b1, 1'b0, 8, -1, 3);
    check("after_reset_rx_zero", rx_data, 8'h00);
    mw[0] = 8'h3D;
    run_frame(1'b1, 1'b0, 8, -1, -1);
    check("after_reset_rx", rx_data, 8'h3D);

    // Mode 00 with polarity/phase pins toggled mid-word, then a mode 10 frame.
    mw[0] = 8'hC9;
    run_frame(1'b0, 1'b0, 8, 4, -1);
    check("toggle_rx", rx_data, 8'hC9);
    mw[0] = 8'h71;
    run_frame(1'b1, 1'b0, 8, -1, -1);
    check("new_mode_rx", rx_data, 8'h71);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      cp = 1'($urandom);
      ch = 1'($urandom);
      if ($urandom_range(3, 0) == 0) nb = $urandom_range(23, 1);
      else nb = 8 * $urandom_range(3, 1);
      tg = ($urandom_range(1, 0) == 1) ? $urandom_range(nb - 1, 0) : -1;
      ra = ($urandom_range(9, 0) == 0) ? $urandom_range(nb - 1, 0) : -1;
      for (int k = 0; k < 4; k++) mw[k] = 8'($urandom);
      run_frame(cp, ch, nb, tg, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
